// File: rtl/io_mmio_ctrl.sv
// Memory-mapped I/O controller: LED/display registers, synchronized switches and
// buttons with sticky rising-edge flags, and a down-counting timer with interrupt.
module io_mmio_ctrl #(
  parameter int TIMER_W = 32,
  parameter int BTN_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        rvalid,
  input  logic [31:0] switch_in,
  input  logic [31:0] button_in,
  output logic [31:0] display_out,
  output logic [31:0] led_out,
  output logic        timer_int
);

  localparam logic [5:0] SEL_SW     = 6'h00;
  localparam logic [5:0] SEL_BTN    = 6'h01;
  localparam logic [5:0] SEL_EDGE   = 6'h02;
  localparam logic [5:0] SEL_LED    = 6'h03;
  localparam logic [5:0] SEL_DISP   = 6'h04;
  localparam logic [5:0] SEL_TCTRL  = 6'h05;
  localparam logic [5:0] SEL_TLOAD  = 6'h06;
  localparam logic [5:0] SEL_TCOUNT = 6'h07;
  localparam logic [5:0] SEL_TSTAT  = 6'h08;

  logic [31:0]        sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [BTN_W-1:0]   btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d, btn_s3_q, btn_s3_d;
  logic [BTN_W-1:0]   edge_q, edge_d;
  logic [31:0]        led_q, led_d, disp_q, disp_d;
  logic               en_q, en_d, reload_q, reload_d, ie_q, ie_d;
  logic [TIMER_W-1:0] tload_q, tload_d, count_q, count_d;
  logic               exp_q, exp_d, int_q, int_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;

  logic [5:0]         sel_s;
  logic [BTN_W-1:0]   edge_clr_s;
  logic               exp_clr_s, tload_wr_s, tctrl_wr_s, hw_exp_s, hw_stop_s;
  logic [31:0]        rd_s;
  logic               unused_s;

  assign sel_s    = addr[7:2];
  assign unused_s = ^{addr[1:0], button_in};

  // Next-state logic: synchronizers, register writes, timer and read mux.
  always_comb begin
    sw_s1_d    = switch_in;
    sw_s2_d    = sw_s1_q;
    btn_s1_d   = button_in[BTN_W-1:0];
    btn_s2_d   = btn_s1_q;
    btn_s3_d   = btn_s2_q;
    led_d      = led_q;
    disp_d     = disp_q;
    reload_d   = reload_q;
    ie_d       = ie_q;
    tload_d    = tload_q;
    count_d    = count_q;
    edge_clr_s = '0;
    exp_clr_s  = 1'b0;
    tload_wr_s = 1'b0;
    tctrl_wr_s = 1'b0;
    hw_exp_s   = 1'b0;
    hw_stop_s  = 1'b0;
    rd_s       = 32'd0;

    if (we) begin
      case (sel_s)
        SEL_EDGE:  edge_clr_s = wdata[BTN_W-1:0];
        SEL_LED:   led_d      = wdata;
        SEL_DISP:  disp_d     = wdata;
        SEL_TCTRL: begin
          tctrl_wr_s = 1'b1;
          reload_d   = wdata[1];
          ie_d       = wdata[2];
        end
        SEL_TLOAD: tload_wr_s = 1'b1;
        SEL_TSTAT: exp_clr_s  = wdata[0];
        default:   tctrl_wr_s = 1'b0;
      endcase
    end else begin
      tctrl_wr_s = 1'b0;
    end

    // A TLOAD write preempts the whole timer step, including expiry.
    if (tload_wr_s) begin
      tload_d = wdata[TIMER_W-1:0];
      count_d = wdata[TIMER_W-1:0];
    end else if (en_q) begin
      if (count_q != '0) begin
        count_d = count_q - TIMER_W'(1);
      end else if (reload_q) begin
        count_d  = tload_q;
        hw_exp_s = 1'b1;
      end else begin
        hw_exp_s  = 1'b1;
        hw_stop_s = 1'b1;
      end
    end else begin
      count_d = count_q;
    end

    if (tctrl_wr_s) begin
      en_d = wdata[0];
    end else if (hw_stop_s) begin
      en_d = 1'b0;
    end else begin
      en_d = en_q;
    end

    edge_d = (edge_q & ~edge_clr_s) | (btn_s2_q & ~btn_s3_q);
    exp_d  = (exp_q & ~exp_clr_s) | hw_exp_s;
    int_d  = exp_q & ie_q;

    case (sel_s)
      SEL_SW:     rd_s = sw_s2_q;
      SEL_BTN:    rd_s[BTN_W-1:0] = btn_s2_q;
      SEL_EDGE:   rd_s[BTN_W-1:0] = edge_q;
      SEL_LED:    rd_s = led_q;
      SEL_DISP:   rd_s = disp_q;
      SEL_TCTRL:  rd_s[2:0] = {ie_q, reload_q, en_q};
      SEL_TLOAD:  rd_s[TIMER_W-1:0] = tload_q;
      SEL_TCOUNT: rd_s[TIMER_W-1:0] = count_q;
      SEL_TSTAT:  rd_s[0] = exp_q;
      default:    rd_s = 32'd0;
    endcase

    if (re) begin
      rdata_d = rd_s;
    end else begin
      rdata_d = rdata_q;
    end
    rvalid_d = re;
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1_q  <= 32'd0;
      sw_s2_q  <= 32'd0;
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      btn_s3_q <= '0;
      edge_q   <= '0;
      led_q    <= 32'd0;
      disp_q   <= 32'd0;
      en_q     <= 1'b0;
      reload_q <= 1'b0;
      ie_q     <= 1'b0;
      tload_q  <= '0;
      count_q  <= '0;
      exp_q    <= 1'b0;
      int_q    <= 1'b0;
      rdata_q  <= 32'd0;
      rvalid_q <= 1'b0;
    end else begin
      sw_s1_q  <= sw_s1_d;
      sw_s2_q  <= sw_s2_d;
      btn_s1_q <= btn_s1_d;
      btn_s2_q <= btn_s2_d;
      btn_s3_q <= btn_s3_d;
      edge_q   <= edge_d;
      led_q    <= led_d;
      disp_q   <= disp_d;
      en_q     <= en_d;
      reload_q <= reload_d;
      ie_q     <= ie_d;
      tload_q  <= tload_d;
      count_q  <= count_d;
      exp_q    <= exp_d;
      int_q    <= int_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata       = rdata_q;
  assign rvalid      = rvalid_q;
  assign display_out = disp_q;
  assign led_out     = led_q;
  assign timer_int   = int_q;

endmodule

// File: doc/io_mmio_ctrl.md
# io_mmio_ctrl

Memory-mapped I/O controller between the CPU data bus and board-level I/O. It registers the LED and 7-segment display words. It synchronizes switches and debounced buttons and captures button rising edges as sticky bits. It also contains a down-counting timer that drives `timer_int`. Its outputs feed the display scanner (lower 16 bits shown) and the LED pins.

## Interface

- `TIMER_W`, default 32: timer counter/load width, 1..32; upper bits of readback are zero.
- `BTN_W`, default 5: number of button inputs captured for edge detection, 1..32.

Ports:

- `clk` input, 1: CPU clock; single clock domain.
- `rst` input, 1: reset, asynchronous, active-high.
- `addr` input, 8: byte address; `addr[1:0]` ignored; `addr[7:2]` selects the register.
- `we` input, 1: write strobe, one write per cycle.
- `wdata` input, 32: write data.
- `re` input, 1: read strobe.
- `rdata` output, 32: read data, registered.
- `rvalid` output, 1: high for exactly one cycle, the cycle after `re`.
- `switch_in` input, 32: raw switch levels, asynchronous.
- `button_in` input, 32: debounced button levels, asynchronous; bits ≥ `BTN_W` are ignored.
- `display_out` output, 32: display register.
- `led_out` output, 32: LED register.
- `timer_int` output, 1: level interrupt, registered.

## Operation

Register map (offsets):

- 0x00 SW, RO: switches after the 2-flop synchronizer.
- 0x04 BTN, RO: buttons after the 2-flop synchronizer; bits ≥ `BTN_W` read 0.
- 0x08 BTN_EDGE, R/W1C: sticky rising-edge flags.
  - Set when synced bit goes 0→1 (compared against a third, delay flop).
  - Writing 1 clears the bit; writing 0 has no effect.
- 0x0C LED, RW: drives `led_out` directly.
- 0x10 DISP, RW: drives `display_out` directly.
- 0x14 TCTRL, RW: bit0 EN, bit1 RELOAD, bit2 IE; other bits read 0.
- 0x18 TLOAD, RW: writing also copies the value into COUNT the same edge.
- 0x1C TCOUNT, RO: current count.
- 0x20 TSTAT, R/W1C: bit0 EXP, the sticky expiry flag.
- Unmapped offsets: reads return 0; writes are ignored.

Timer, evaluated each cycle while EN=1 (nothing counts while EN=0):

- COUNT≠0: COUNT decrements by 1.
- COUNT==0 with RELOAD=1: COUNT←TLOAD and EXP←1.
- COUNT==0 with RELOAD=0: EXP←1 and EN←0; COUNT stays 0.
- TLOAD=0 with RELOAD=1: EXP is set on every enabled cycle.

Interrupt: `timer_int` ← EXP & IE, registered, so it lags EXP by one cycle.

Conflict rules:

- Hardware set beats software W1C in the same cycle, for both BTN_EDGE and EXP.
- A TLOAD write beats timer decrement/reload in the same cycle.
- A TCTRL write beats the hardware clear of EN in the same cycle.
- Read and write to the same register in the same cycle: the read returns the pre-write value.

## Timing

- Reset values: `rdata`=0, `rvalid`=0, `display_out`=0, `led_out`=0, `timer_int`=0, all internal registers and synchronizer flops 0.
- Reset asserted mid-count clears the timer immediately, without waiting for a clock.
- Read latency: `re` sampled at edge N; `rdata`/`rvalid` are valid after edge N, i.e. during the following cycle. `rdata` holds its value until the next read.
- Write latency: a register written at edge N shows the new value on its output after edge N.
- Input latency:
  - Switch/button change → visible in SW/BTN after 2 edges.
  - BTN_EDGE bit sets 3 edges after the input rise.
- Expiry latency: with TLOAD=L and EN set at edge N, EXP sets at edge N+L+1 and `timer_int` rises at N+L+2.

## Test plan

- Reset: hold `rst` high mid-run → all outputs 0 asynchronously. Then write LED=0x0000A5A5 and read 0x0C → `rvalid` pulses one cycle later with `rdata`=0x0000A5A5.
- Synchronizer/edge: `button_in[2]` 0→1 → BTN bit2=1 after 2 edges, BTN_EDGE=0x4 after 3 edges. Write 0x4 to 0x08 → reads 0. A W1C issued in the same cycle as a new edge leaves the bit set.
- One-shot timer: TLOAD=5, TCTRL=0x5 → TCOUNT reads 5,4,…,0. EXP=1 and EN clears at the expiry edge; `timer_int`=1 one cycle later. W1C to TSTAT → `timer_int` falls the following cycle.
- Auto-reload: TLOAD=3, TCTRL=0x7 → EXP sets every 4 cycles and COUNT reloads to 3. Clearing IE drops `timer_int` while EXP stays 1.
- Collisions: a TLOAD=10 write in the cycle COUNT hits 0 → COUNT=10 and EXP not set. A read of TCOUNT in the same cycle returns the old value.
- Unmapped: read 0x3C → 0. Write 0xFFFFFFFF to 0x24 → no register changes.
